// File: rtl/prio_arbiter_readout_pkg.sv
// Shared types and helpers for the lane arbiter / readout stage.
package prio_arbiter_readout_pkg;

   localparam int unsigned MAX_LANE  = 16;
   localparam int unsigned MAX_IDX_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ARB,
      ST_DRAIN
   } state_e;

   // Isolate the lowest set bit of a request vector.
   function automatic logic [MAX_LANE-1:0] onehot_lowest(input logic [MAX_LANE-1:0] vec);
      return vec & (~vec + MAX_LANE'(1));
   endfunction

   // Encode a one-hot vector into its bit index (zero when empty).
   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_LANE-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_LANE; i++) begin
         if (oh[i]) idx = idx | MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/prio_arbiter_readout_pick.sv
// Combinational lowest-index pick: one-hot, index and any-set flag.
module prio_arbiter_readout_pick
   import prio_arbiter_readout_pkg::*;
#(
   parameter  int unsigned NLANE = 4,
   localparam int unsigned IDX_W = $clog2(NLANE)
) (
   input  logic [NLANE-1:0] req_i,
   output logic [NLANE-1:0] oh_c_o,
   output logic [IDX_W-1:0] idx_c_o,
   output logic             any_c_o
);

   logic [MAX_LANE-1:0] oh_wide;

   // Widen to the helper width, pick, then narrow back to the lane count.
   assign oh_wide = onehot_lowest(MAX_LANE'(req_i));
   assign oh_c_o  = NLANE'(oh_wide);
   assign idx_c_o = IDX_W'(onehot_to_idx(oh_wide));
   assign any_c_o = |req_i;

endmodule

// File: rtl/prio_arbiter_readout.sv
// Fixed-priority lane arbiter with merged, registered readout stream.
module prio_arbiter_readout
   import prio_arbiter_readout_pkg::*;
#(
   parameter  int unsigned NLANE  = 4,
   parameter  int unsigned DATA_W = 36,
   parameter  int unsigned CNT_W  = 8,
   localparam int unsigned IDX_W  = $clog2(NLANE)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    init_i,
   input  logic                    setup_i,
   input  logic [NLANE-1:0]        has_dat_i,
   input  logic [NLANE-1:0]        lane_valid_i,
   input  logic [NLANE*DATA_W-1:0] lane_dat_i,
   output logic [NLANE-1:0]        sel_o,
   output logic                    out_valid_o,
   output logic [DATA_W-1:0]       out_dat_o,
   output logic [IDX_W-1:0]        out_lane_o,
   output logic                    out_first_o,
   output logic [CNT_W-1:0]        out_cnt_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);

   state_e             state_q, state_d;
   logic [NLANE-1:0]   sel_q, sel_d;
   logic [IDX_W-1:0]   cur_q, cur_d;
   logic               done_q, done_d;
   logic               busy_q;
   logic               out_valid_q, out_first_q, armed_q, err_q;
   logic [DATA_W-1:0]  out_dat_q;
   logic [IDX_W-1:0]   out_lane_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [NLANE-1:0]   grant_oh, rd_oh;
   logic [IDX_W-1:0]   grant_idx, rd_idx;
   logic               grant_any, rd_any, rd_take, err_hit;
   logic [DATA_W-1:0]  rd_word;

   prio_arbiter_readout_pick #(.NLANE(NLANE)) u_pick_grant (
      .req_i   (has_dat_i),
      .oh_c_o  (grant_oh),
      .idx_c_o (grant_idx),
      .any_c_o (grant_any)
   );

   prio_arbiter_readout_pick #(.NLANE(NLANE)) u_pick_read (
      .req_i   (lane_valid_i),
      .oh_c_o  (rd_oh),
      .idx_c_o (rd_idx),
      .any_c_o (rd_any)
   );

   // Next-state and grant decision; init overrides every state.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cur_d   = cur_q;
      done_d  = 1'b0;
      if (init_i) begin
         state_d = ST_WAIT;
         sel_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_WAIT: begin
               sel_d = '0;
               if (!setup_i) state_d = ST_ARB;
            end
            ST_ARB: begin
               if (grant_any) begin
                  sel_d   = grant_oh;
                  cur_d   = grant_idx;
                  state_d = ST_DRAIN;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (!has_dat_i[cur_q]) begin
                  sel_d   = '0;
                  state_d = ST_ARB;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // AND-OR mux of the lowest valid lane's word, plus protocol error detect.
   always_comb begin
      rd_word = '0;
      for (int unsigned i = 0; i < NLANE; i++) begin
         if (rd_oh[i]) rd_word = rd_word | lane_dat_i[i*DATA_W +: DATA_W];
      end
      rd_take = rd_any & ~init_i;
      err_hit = (|(lane_valid_i & (lane_valid_i - NLANE'(1)))) | (|(lane_valid_i & ~sel_q));
   end

   // FSM, grant and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         cur_q       <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_dat_q   <= '0;
         out_lane_q  <= '0;
         out_first_q <= 1'b0;
         armed_q     <= 1'b0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         cur_q       <= cur_d;
         done_q      <= done_d;
         busy_q      <= (state_d != ST_IDLE);
         out_valid_q <= rd_take;
         out_first_q <= rd_take & armed_q;
         if (rd_take) begin
            out_dat_q  <= rd_word;
            out_lane_q <= rd_idx;
         end
         if (init_i) begin
            armed_q <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
         end else begin
            if (rd_take) armed_q <= 1'b0;
            if (out_valid_q && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
            if (err_hit) err_q <= 1'b1;
         end
      end
   end

   assign sel_o       = sel_q;
   assign out_valid_o = out_valid_q;
   assign out_dat_o   = out_dat_q;
   assign out_lane_o  = out_lane_q;
   assign out_first_o = out_first_q;
   assign out_cnt_o   = cnt_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule
